// File: rtl/pingpong_ram_ctrl.sv
// Two-bank ping-pong frame buffer: frames are written row-major into one bank
// and read back column-major, so the output stream is the transposed matrix.
//
// state   | meaning
// W_IDLE  | waiting for wr_command
// W_ARM   | latch write bank, clear write counter
// W_RUN   | accept data_in beats until DEPTH written
// R_IDLE  | waiting for rd_command
// R_ARM   | latch read bank, clear row/col
// R_RUN   | issue one column-major read per cycle
// R_DRAIN | wait out the registered RAM output
module pingpong_ram_ctrl #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              wr_command,
  input  logic              wr_ram_number,
  input  logic              rd_command,
  input  logic              rd_ram_number,
  output logic              wr_finish_0,
  output logic              wr_finish_1,
  output logic              rd_finish_0,
  output logic              rd_finish_1,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              cmd_err
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  typedef enum logic [1:0] {W_IDLE, W_ARM, W_RUN} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ARM, R_RUN, R_DRAIN} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  logic              wr_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic              wr_beat;
  logic              wr_last;

  logic              rd_bank;
  logic [ADDR_W-1:0] rd_row;
  logic [ADDR_W-1:0] rd_col;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_issue;
  logic              rd_last;

  assign wr_beat  = (wr_state == W_RUN) && data_in_valid;
  assign wr_last  = wr_beat && (wr_cnt == LAST);
  assign rd_issue = (rd_state == R_RUN);
  assign rd_addr  = rd_row * COLS_A + rd_col;
  assign rd_last  = rd_issue && (rd_row == ROW_LAST) && (rd_col == COL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (wr_command) wr_next = W_ARM;
      W_ARM:   wr_next = W_RUN;
      W_RUN:   if (wr_last) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (rd_command) rd_next = R_ARM;
      R_ARM:   rd_next = R_RUN;
      R_RUN:   if (rd_last) rd_next = R_DRAIN;
      R_DRAIN: rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // RAM contents survive reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (wr_beat) begin
      if (wr_bank) mem1[wr_cnt] <= data_in;
      else         mem0[wr_cnt] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      wr_cnt      <= '0;
      wr_finish_0 <= 1'b0;
      wr_finish_1 <= 1'b0;
    end else begin
      wr_finish_0 <= wr_last && !wr_bank;
      wr_finish_1 <= wr_last && wr_bank;
      if (wr_state == W_ARM) begin
        wr_bank <= wr_ram_number;
        wr_cnt  <= '0;
      end else if (wr_last) begin
        wr_cnt <= '0;
      end else if (wr_beat) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Row is the inner loop, so consecutive reads walk down a column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank        <= 1'b0;
      rd_row         <= '0;
      rd_col         <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      rd_finish_0    <= 1'b0;
      rd_finish_1    <= 1'b0;
    end else begin
      data_out_valid <= rd_issue;
      rd_finish_0    <= rd_last && !rd_bank;
      rd_finish_1    <= rd_last && rd_bank;
      if (rd_issue) data_out <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
      if (rd_state == R_ARM) begin
        rd_bank <= rd_ram_number;
        rd_row  <= '0;
        rd_col  <= '0;
      end else if (rd_issue) begin
        if (rd_row == ROW_LAST) begin
          rd_row <= '0;
          rd_col <= rd_col + 1'b1;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err <= 1'b0;
    end else if ((wr_command && wr_state != W_IDLE) ||
                 (rd_command && rd_state != R_IDLE)) begin
      cmd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
// Scoreboard bench for pingpong_ram_ctrl: read tasks queue the expected
// transposed stream, a forked monitor pops and compares on data_out_valid.
module tb_pingpong_ram_ctrl;

  localparam int DW    = 16;
  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int DEPTH = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          wr_command;
  logic          wr_ram_number;
  logic          rd_command;
  logic          rd_ram_number;
  logic          wr_finish_0;
  logic          wr_finish_1;
  logic          rd_finish_0;
  logic          rd_finish_1;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          cmd_err;

  pingpong_ram_ctrl #(.DATA_W(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .wr_command(wr_command), .wr_ram_number(wr_ram_number),
    .rd_command(rd_command), .rd_ram_number(rd_ram_number),
    .wr_finish_0(wr_finish_0), .wr_finish_1(wr_finish_1),
    .rd_finish_0(rd_finish_0), .rd_finish_1(rd_finish_1),
    .data_out(data_out), .data_out_valid(data_out_valid), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          f0;
    logic          f1;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model [2][DEPTH];
  int            checks = 0;
  int            errors = 0;
  bit            mon_on = 1'b1;
  bit            in_burst = 1'b0;
  int            wf0 = 0, wf1 = 0, rf0 = 0, rf1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_finish_0) wf0++;
      if (wr_finish_1) wf1++;
      if (rd_finish_0) rf0++;
      if (rd_finish_1) rf1++;
      if (!mon_on) begin
        in_burst = 1'b0;
      end else if (data_out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=%0d expected=none", data_out);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (data_out !== e.d || rd_finish_0 !== e.f0 || rd_finish_1 !== e.f1) begin
            errors++;
            $display("FAIL rd_data actual=%0d/%0b/%0b expected=%0d/%0b/%0b",
                     data_out, rd_finish_0, rd_finish_1, e.d, e.f0, e.f1);
          end
          in_burst = (exp_q.size() != 0);
        end
      end else begin
        if (in_burst) chk("rd_valid_gap", {31'd0, data_out_valid}, 32'd1);
        in_burst = 1'b0;
        if (rd_finish_0 || rd_finish_1)
          chk("rd_finish_stray", {30'd0, rd_finish_1, rd_finish_0}, 32'd0);
      end
    end
  endtask

  task automatic write_frame(input bit bank, input int base, input bit gapped, input int busy_at);
    int p0 = wf0;
    int p1 = wf1;
    @(posedge clk); #1;
    wr_command = 1'b1; wr_ram_number = bank;
    @(posedge clk); #1;
    wr_command = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) begin
      data_in = DW'(base + i);
      data_in_valid = 1'b1;
      if (i == busy_at) begin
        wr_command = 1'b1; wr_ram_number = ~bank;
      end
      model[bank][i] = DW'(base + i);
      @(posedge clk); #1;
      wr_command = 1'b0; wr_ram_number = bank; data_in_valid = 1'b0;
      if (gapped && i != DEPTH - 1) begin
        data_in = 16'hdead;
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("wr_finish_own", {31'd0, bank ? wr_finish_1 : wr_finish_0}, 32'd1);
    chk("wr_finish_other", {31'd0, bank ? wr_finish_0 : wr_finish_1}, 32'd0);
    @(posedge clk); #1;
    chk("wr_finish_cnt0", wf0, p0 + (bank ? 0 : 1));
    chk("wr_finish_cnt1", wf1, p1 + (bank ? 1 : 0));
  endtask

  task automatic read_frame(input bit bank);
    exp_t e;
    int   t;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        e.d  = model[bank][r * COLS + c];
        e.f0 = (c == COLS - 1) && (r == ROWS - 1) && !bank;
        e.f1 = (c == COLS - 1) && (r == ROWS - 1) && bank;
        exp_q.push_back(e);
      end
    @(posedge clk); #1;
    rd_command = 1'b1; rd_ram_number = bank;
    @(posedge clk); #1;
    rd_command = 1'b0;
    for (t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    chk("rd_frame_left", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int p0, p1, q0, q1;
    rst = 1'b1; data_in = '0; data_in_valid = 1'b0;
    wr_command = 1'b0; wr_ram_number = 1'b0;
    rd_command = 1'b0; rd_ram_number = 1'b0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", {31'd0, data_out_valid}, 0);
    chk("rst_finish", {28'd0, wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1}, 0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single frame through bank0
    write_frame(1'b0, 0, 1'b0, -1);
    read_frame(1'b0);

    // ping-pong: fill bank1, then write bank0 while reading bank1
    write_frame(1'b1, 100, 1'b0, -1);
    fork
      write_frame(1'b0, 200, 1'b0, -1);
      read_frame(1'b1);
    join
    read_frame(1'b0);

    // gapped input
    write_frame(1'b1, 300, 1'b1, -1);
    read_frame(1'b1);

    // stray valid while idle
    p0 = wf0; p1 = wf1;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'hbeef; data_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    chk("stray_no_finish", wf0 + wf1, p0 + p1);
    chk("stray_cmd_err", {31'd0, cmd_err}, 0);
    read_frame(1'b1);

    // busy command mid-frame
    write_frame(1'b0, 400, 1'b0, 10);
    chk("busy_cmd_err", {31'd0, cmd_err}, 1);
    read_frame(1'b0);
    chk("busy_cmd_err_sticky", {31'd0, cmd_err}, 1);

    // reset during a write and a read
    mon_on = 1'b0;
    p0 = wf0 + wf1; q0 = rf0 + rf1;
    @(posedge clk); #1;
    rd_command = 1'b1; rd_ram_number = 1'b1;
    wr_command = 1'b1; wr_ram_number = 1'b0;
    @(posedge clk); #1;
    rd_command = 1'b0; wr_command = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      data_in = DW'(600 + i); data_in_valid = 1'b1;
      model[0][i] = DW'(600 + i);
      @(posedge clk); #1;
    end
    data_in = DW'(615);
    rst = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    chk("midrst_data_out", data_out, 0);
    chk("midrst_valid", {31'd0, data_out_valid}, 0);
    chk("midrst_finish", {28'd0, wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1}, 0);
    chk("midrst_cmd_err", {31'd0, cmd_err}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    p1 = wf0 + wf1; q1 = rf0 + rf1;
    chk("midrst_no_wr_finish", p1, p0);
    chk("midrst_no_rd_finish", q1, q0);
    mon_on = 1'b1;

    write_frame(1'b0, 500, 1'b0, -1);
    read_frame(1'b0);
    read_frame(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
